// File: rtl/rob_complete_arbiter_pkg.sv
// Shared definitions for the ROB completion arbiter: payload layout and source ids.
package rob_complete_arbiter_pkg;

  localparam int SRC_ALU  = 0;
  localparam int SRC_LDST = 1;
  localparam int SRC_BR   = 2;

  // Payload packs {targetPC, taken, exc, robIdx} with the ROB index at bit 0.
  localparam int PL_IDX = 0;

  function automatic int pl_exc(input int aw);
    return aw;
  endfunction

  function automatic int pl_taken(input int aw);
    return aw + 1;
  endfunction

  function automatic int pl_tpc(input int aw);
    return aw + 2;
  endfunction

  function automatic int payload_w(input int aw, input int pw);
    return aw + 2 + pw;
  endfunction

endpackage

// File: rtl/rob_complete_arbiter_rr_pick.sv
// Rotate-priority picker: first valid index at or above the pointer, with wrap-around.
module rob_complete_arbiter_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_vld,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_win,
  output logic               o_any
);

  always_comb begin : pick
    logic [PTR_W-1:0] w_idx;
    o_grant = '0;
    o_win   = '0;
    o_any   = 1'b0;
    w_idx   = '0;
    // Scan farthest offset first so the nearest valid index overrides.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
      if (i_vld[w_idx]) begin
        o_grant        = '0;
        o_grant[w_idx] = 1'b1;
        o_win          = w_idx;
        o_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_complete_arbiter.sv
// Buffers one completion per execution source and issues one ROB finish write per cycle, round-robin.
module rob_complete_arbiter
  import rob_complete_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int ROB_ADDRWIDTH = 6,
  parameter int PC_WIDTH      = 32,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          FREEZE,
  input  logic                          tARB_flush_IN,
  input  logic [NUM_REQ-1:0]            tARB_req_IN,
  input  logic [NUM_REQ*ROB_ADDRWIDTH-1:0] tARB_robIdx_IN,
  input  logic [NUM_REQ-1:0]            tARB_exc_IN,
  input  logic [NUM_REQ-1:0]            tARB_taken_IN,
  input  logic [NUM_REQ*PC_WIDTH-1:0]   tARB_targetPC_IN,
  output logic [NUM_REQ-1:0]            fARB_ready_OUT,
  output logic [ROB_ADDRWIDTH-1:0]      fARB_probeIdx_OUT,
  output logic                          fARB_setFin_OUT,
  output logic                          fARB_setExp_OUT,
  output logic                          fARB_taken_OUT,
  output logic [PC_WIDTH-1:0]           fARB_targetPC_OUT,
  output logic [NUM_REQ-1:0]            fARB_pending_OUT,
  output logic [CNT_WIDTH-1:0]          fARB_doneCount_OUT
);

  localparam int PL_W  = payload_w(ROB_ADDRWIDTH, PC_WIDTH);
  localparam int EXC_O = pl_exc(ROB_ADDRWIDTH);
  localparam int TK_O  = pl_taken(ROB_ADDRWIDTH);
  localparam int TPC_O = pl_tpc(ROB_ADDRWIDTH);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       r_hold_vld;
  logic [PL_W-1:0]          r_hold_pl [NUM_REQ];
  logic [PTR_W-1:0]         r_rr_ptr;
  logic [ROB_ADDRWIDTH-1:0] r_probe_idx;
  logic                     r_set_fin;
  logic                     r_set_exp;
  logic                     r_taken;
  logic [PC_WIDTH-1:0]      r_target_pc;
  logic [CNT_WIDTH-1:0]     r_done_cnt;

  logic                     w_en;
  logic [NUM_REQ-1:0]       w_pick_grant;
  logic [PTR_W-1:0]         w_win;
  logic                     w_pick_any;
  logic [NUM_REQ-1:0]       w_grant;
  logic                     w_fire;
  logic [NUM_REQ-1:0]       w_ready;
  logic [NUM_REQ-1:0]       w_accept;
  logic [PL_W-1:0]          w_win_pl;
  logic [PTR_W-1:0]         w_rr_next;

  rob_complete_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .i_vld   (r_hold_vld),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_win   (w_win),
    .o_any   (w_pick_any)
  );

  assign w_en      = !RESET && !FREEZE && !tARB_flush_IN;
  assign w_grant   = w_en ? w_pick_grant : '0;
  assign w_fire    = w_en && w_pick_any;
  // A hold being drained this cycle can take a new record, so a lone source streams.
  assign w_ready   = {NUM_REQ{w_en}} & (~r_hold_vld | w_grant);
  assign w_accept  = tARB_req_IN & w_ready;
  assign w_win_pl  = r_hold_pl[w_win];
  assign w_rr_next = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + PTR_W'(1);

  // Hold capture: payload only, qualified by hold_valid
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_accept[i]) begin
        r_hold_pl[i] <= {tARB_targetPC_IN[i*PC_WIDTH +: PC_WIDTH], tARB_taken_IN[i],
                         tARB_exc_IN[i], tARB_robIdx_IN[i*ROB_ADDRWIDTH +: ROB_ADDRWIDTH]};
      end
    end
  end

  // Issue stage: ROB-side registers, pointer and counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hold_vld  <= '0;
      r_rr_ptr    <= '0;
      r_done_cnt  <= '0;
      r_probe_idx <= '0;
      r_set_fin   <= 1'b0;
      r_set_exp   <= 1'b0;
      r_taken     <= 1'b0;
      r_target_pc <= '0;
    end else if (tARB_flush_IN) begin
      r_hold_vld <= '0;
      r_rr_ptr   <= '0;
      r_set_fin  <= 1'b0;
    end else if (FREEZE) begin
      r_set_fin <= 1'b0;
    end else begin
      r_hold_vld <= (r_hold_vld & ~w_grant) | w_accept;
      r_set_fin  <= w_fire;
      if (w_fire) begin
        r_probe_idx <= w_win_pl[PL_IDX +: ROB_ADDRWIDTH];
        r_set_exp   <= w_win_pl[EXC_O];
        r_taken     <= w_win_pl[TK_O];
        r_target_pc <= w_win_pl[TPC_O +: PC_WIDTH];
        r_rr_ptr    <= w_rr_next;
        r_done_cnt  <= r_done_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign fARB_ready_OUT     = w_ready;
  assign fARB_probeIdx_OUT  = r_probe_idx;
  assign fARB_setFin_OUT    = r_set_fin;
  assign fARB_setExp_OUT    = r_set_exp;
  assign fARB_taken_OUT     = r_taken;
  assign fARB_targetPC_OUT  = r_target_pc;
  assign fARB_pending_OUT   = r_hold_vld;
  assign fARB_doneCount_OUT = r_done_cnt;

endmodule

// File: tb/tb_rob_complete_arbiter.sv
// Directed bench for rob_complete_arbiter: ordering, payload transfer, flush, freeze, streaming.
module tb_rob_complete_arbiter;
  import rob_complete_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int AW = 6;
  localparam int PW = 32;
  localparam int CW = 16;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            FREEZE;
  logic            flush;
  logic [NR-1:0]   req;
  logic [NR*AW-1:0] idx;
  logic [NR-1:0]   exc;
  logic [NR-1:0]   tk;
  logic [NR*PW-1:0] tpc;
  logic [NR-1:0]   ready;
  logic [AW-1:0]   probe;
  logic            fin;
  logic            sexp;
  logic            taken;
  logic [PW-1:0]   tpc_o;
  logic [NR-1:0]   pend;
  logic [CW-1:0]   cnt;

  int n_total = 0;
  int n_bad   = 0;

  rob_complete_arbiter #(
    .NUM_REQ(NR), .ROB_ADDRWIDTH(AW), .PC_WIDTH(PW), .CNT_WIDTH(CW)
  ) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .FREEZE             (FREEZE),
    .tARB_flush_IN      (flush),
    .tARB_req_IN        (req),
    .tARB_robIdx_IN     (idx),
    .tARB_exc_IN        (exc),
    .tARB_taken_IN      (tk),
    .tARB_targetPC_IN   (tpc),
    .fARB_ready_OUT     (ready),
    .fARB_probeIdx_OUT  (probe),
    .fARB_setFin_OUT    (fin),
    .fARB_setExp_OUT    (sexp),
    .fARB_taken_OUT     (taken),
    .fARB_targetPC_OUT  (tpc_o),
    .fARB_pending_OUT   (pend),
    .fARB_doneCount_OUT (cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    req = '0; idx = '0; exc = '0; tk = '0; tpc = '0;
  endtask

  task automatic set_src(input int s, input logic [AW-1:0] ix, input logic e,
                         input logic t, input logic [PW-1:0] pc);
    req[s]           = 1'b1;
    exc[s]           = e;
    tk[s]            = t;
    idx[s*AW +: AW]  = ix;
    tpc[s*PW +: PW]  = pc;
  endtask

  task automatic chk_iss(input string tag, input logic [AW-1:0] ix, input logic e,
                         input logic t, input logic [PW-1:0] pc);
    chk({tag, ".fin"}, fin, 1'b1);
    chk({tag, ".idx"}, probe, ix);
    chk({tag, ".exp"}, sexp, e);
    chk({tag, ".tk"}, taken, t);
    chk({tag, ".pc"}, tpc_o, pc);
  endtask

  initial begin
    RESET = 1'b1; FREEZE = 1'b0; flush = 1'b0; clr();
    tick(); tick();
    chk("rst.fin", fin, 1'b0);
    chk("rst.idx", probe, 0);
    chk("rst.cnt", cnt, 0);
    chk("rst.pend", pend, 0);
    chk("rst.pc", tpc_o, 0);
    chk("rst.ready", ready, 3'b000);
    RESET = 1'b0; #1;
    chk("post_rst.ready", ready, 3'b111);

    // Lone LD/ST completion
    set_src(SRC_LDST, 6'd5, 1'b0, 1'b0, 32'h0);
    tick();
    chk("t1.pend", pend, 3'b010);
    chk("t1.fin0", fin, 1'b0);
    clr(); tick();
    chk_iss("t1", 6'd5, 1'b0, 1'b0, 32'h0);
    chk("t1.cnt", cnt, 1);
    chk("t1.pend2", pend, 3'b000);
    tick();
    chk("t1.fin_off", fin, 1'b0);

    // rr_ptr now 2: source 2 before source 0
    set_src(SRC_ALU, 6'd10, 1'b0, 1'b0, 32'h0);
    set_src(SRC_BR,  6'd12, 1'b0, 1'b0, 32'h0);
    tick();
    chk("wrap.pend", pend, 3'b101);
    clr(); tick();
    chk_iss("wrap.a", 6'd12, 1'b0, 1'b0, 32'h0);
    chk("wrap.pend_a", pend, 3'b001);
    tick();
    chk_iss("wrap.b", 6'd10, 1'b0, 1'b0, 32'h0);
    tick();
    chk("wrap.fin_off", fin, 1'b0);

    // rr_ptr now 1: source 1 before source 0
    set_src(SRC_ALU,  6'd20, 1'b0, 1'b0, 32'h0);
    set_src(SRC_LDST, 6'd21, 1'b0, 1'b0, 32'h0);
    tick(); clr(); tick();
    chk_iss("rr1.a", 6'd21, 1'b0, 1'b0, 32'h0);
    tick();
    chk_iss("rr1.b", 6'd20, 1'b0, 1'b0, 32'h0);
    tick();
    chk("rr1.cnt", cnt, 5);

    // Flush with three holds valid and a fresh request
    set_src(0, 6'd30, 1'b0, 1'b0, 32'h0);
    set_src(1, 6'd31, 1'b0, 1'b0, 32'h0);
    set_src(2, 6'd32, 1'b0, 1'b0, 32'h0);
    tick();
    chk("fl.pend", pend, 3'b111);
    clr(); flush = 1'b1; set_src(0, 6'd33, 1'b0, 1'b0, 32'h0); #1;
    chk("fl.ready_in", ready, 3'b000);
    tick();
    chk("fl.fin", fin, 1'b0);
    chk("fl.pend0", pend, 3'b000);
    flush = 1'b0; clr(); #1;
    chk("fl.ready_after", ready, 3'b111);
    tick();
    chk("fl.fin2", fin, 1'b0);
    chk("fl.pend2", pend, 3'b000);
    chk("fl.cnt", cnt, 5);

    // All three together from rr_ptr = 0
    set_src(0, 6'd1, 1'b0, 1'b0, 32'h0);
    set_src(1, 6'd2, 1'b0, 1'b0, 32'h0);
    set_src(2, 6'd3, 1'b0, 1'b0, 32'h0);
    tick();
    chk("all.pend", pend, 3'b111);
    clr();
    chk("all.ready0", ready, 3'b001);
    tick();
    chk_iss("all.1", 6'd1, 1'b0, 1'b0, 32'h0);
    chk("all.ready1", ready, 3'b011);
    tick();
    chk_iss("all.2", 6'd2, 1'b0, 1'b0, 32'h0);
    chk("all.ready2", ready, 3'b111);
    tick();
    chk_iss("all.3", 6'd3, 1'b0, 1'b0, 32'h0);
    tick();
    chk("all.fin_off", fin, 1'b0);

    // Branch payload and exception flag
    set_src(SRC_BR,   6'd7, 1'b0, 1'b1, 32'h00400100);
    set_src(SRC_LDST, 6'd9, 1'b1, 1'b0, 32'h0);
    tick(); clr(); tick();
    chk_iss("br.exc", 6'd9, 1'b1, 1'b0, 32'h0);
    tick();
    chk_iss("br.tk", 6'd7, 1'b0, 1'b1, 32'h00400100);
    tick();
    chk("br.fin_off", fin, 1'b0);
    chk("br.idx_hold", probe, 6'd7);
    chk("br.tk_hold", taken, 1'b1);
    chk("br.cnt", cnt, 10);

    // Freeze with two holds pending and rr_ptr = 1
    set_src(0, 6'd40, 1'b0, 1'b0, 32'h0);
    set_src(1, 6'd41, 1'b0, 1'b0, 32'h0);
    set_src(2, 6'd42, 1'b0, 1'b0, 32'h0);
    tick(); clr(); tick();
    chk_iss("fz.pre", 6'd40, 1'b0, 1'b0, 32'h0);
    chk("fz.pend_pre", pend, 3'b110);
    FREEZE = 1'b1; #1;
    chk("fz.ready", ready, 3'b000);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("fz.fin", fin, 1'b0);
      chk("fz.pend", pend, 3'b110);
      chk("fz.cnt", cnt, 11);
    end
    FREEZE = 1'b0;
    tick();
    chk_iss("fz.a", 6'd41, 1'b0, 1'b0, 32'h0);
    tick();
    chk_iss("fz.b", 6'd42, 1'b0, 1'b0, 32'h0);
    tick();
    chk("fz.fin_off", fin, 1'b0);
    chk("fz.cnt2", cnt, 13);

    // Lone ALU source streaming one per cycle
    set_src(SRC_ALU, 6'd50, 1'b0, 1'b0, 32'h0);
    tick();
    chk("ln.pend", pend, 3'b001);
    for (int k = 1; k <= 3; k++) begin
      chk("ln.ready", ready[0], 1'b1);
      set_src(SRC_ALU, 6'(50 + k), 1'b0, 1'b0, 32'h0);
      tick();
      chk_iss("ln.s", 6'(50 + k - 1), 1'b0, 1'b0, 32'h0);
    end
    clr(); tick();
    chk_iss("ln.last", 6'd53, 1'b0, 1'b0, 32'h0);
    tick();
    chk("ln.fin_off", fin, 1'b0);
    chk("ln.cnt", cnt, 17);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
